// File: rtl/spi_axi_mem_slave.sv
// AXI4 memory slave: independent write and read burst engines in front of a byte-enabled
// word memory, supporting FIXED/INCR/WRAP bursts, one outstanding burst per direction.
module spi_axi_mem_slave #(
    parameter int AXI_WIDTH_ID   = 4,
    parameter int AXI_WIDTH_ADDR = 32,
    parameter int AXI_WIDTH_DATA = 32,
    parameter int MEM_WIDTH_AD   = 10
) (
    input  logic                        aclk,
    input  logic                        areset,

    input  logic [AXI_WIDTH_ID-1:0]     s_axi_awid,
    input  logic [AXI_WIDTH_ADDR-1:0]   s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,

    input  logic [AXI_WIDTH_DATA-1:0]   s_axi_wdata,
    input  logic [AXI_WIDTH_DATA/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,

    output logic [AXI_WIDTH_ID-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,

    input  logic [AXI_WIDTH_ID-1:0]     s_axi_arid,
    input  logic [AXI_WIDTH_ADDR-1:0]   s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [1:0]                  s_axi_arburst,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,

    output logic [AXI_WIDTH_ID-1:0]     s_axi_rid,
    output logic [AXI_WIDTH_DATA-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready
);

    localparam int STRB_W   = AXI_WIDTH_DATA / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int DEPTH    = 2 ** MEM_WIDTH_AD;
    localparam logic [AXI_WIDTH_ADDR-1:0] BEAT_BYTES = AXI_WIDTH_ADDR'(STRB_W);
    localparam logic [AXI_WIDTH_ADDR-1:0] LSB_MASK   = AXI_WIDTH_ADDR'(STRB_W - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    function automatic logic burst_bad(input logic [1:0] burst, input logic [7:0] len);
        burst_bad = (burst == 2'd3) ||
                    ((burst == 2'd2) && !((len == 8'd1) || (len == 8'd3) ||
                                          (len == 8'd7) || (len == 8'd15)));
    endfunction

    // WRAP keeps the bits above the burst-sized window and increments within it
    function automatic logic [AXI_WIDTH_ADDR-1:0] addr_next(
        input logic [AXI_WIDTH_ADDR-1:0] addr,
        input logic [1:0]                burst,
        input logic [7:0]                len
    );
        logic [AXI_WIDTH_ADDR-1:0] mask;
        mask = ((AXI_WIDTH_ADDR'(len) + AXI_WIDTH_ADDR'(1)) << ADDR_LSB) - AXI_WIDTH_ADDR'(1);
        case (burst)
            2'd0:    addr_next = addr;
            2'd2:    addr_next = (addr & ~mask) | ((addr + BEAT_BYTES) & mask);
            default: addr_next = addr + BEAT_BYTES;
        endcase
    endfunction

    logic [AXI_WIDTH_DATA-1:0] mem_q [DEPTH];

    wstate_t                   wstate_q;
    logic                      awready_q, wready_q, bvalid_q;
    logic [1:0]                bresp_q;
    logic [AXI_WIDTH_ID-1:0]   bid_q;
    logic [AXI_WIDTH_ADDR-1:0] waddr_q;
    logic [7:0]                wlen_q, wcnt_q;
    logic [1:0]                wburst_q;
    logic                      wbad_q, wlast_err_q;

    rstate_t                   rstate_q;
    logic                      arready_q, rvalid_q, rlast_q;
    logic [1:0]                rresp_q;
    logic [AXI_WIDTH_ID-1:0]   rid_q;
    logic [AXI_WIDTH_DATA-1:0] rdata_q;
    logic [AXI_WIDTH_ADDR-1:0] raddr_q;
    logic [7:0]                rlen_q, rcnt_q;
    logic [1:0]                rburst_q;
    logic                      rbad_q;

    logic                      w_hs, w_last_beat, w_last_err, mem_we;
    logic                      r_hs;
    logic [AXI_WIDTH_ADDR-1:0] waddr_d, raddr_d, araddr_al, awaddr_al;

    assign w_hs        = s_axi_wvalid && wready_q;
    assign w_last_beat = (wcnt_q == wlen_q);
    assign w_last_err  = (s_axi_wlast != w_last_beat);
    assign mem_we      = w_hs && !wbad_q;
    assign waddr_d     = addr_next(waddr_q, wburst_q, wlen_q);
    assign awaddr_al   = s_axi_awaddr & ~LSB_MASK;

    assign r_hs        = rvalid_q && s_axi_rready;
    assign raddr_d     = addr_next(raddr_q, rburst_q, rlen_q);
    assign araddr_al   = s_axi_araddr & ~LSB_MASK;

    // Memory array is intentionally not reset
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (s_axi_wstrb[i]) begin
                    mem_q[waddr_q[ADDR_LSB +: MEM_WIDTH_AD]][8*i +: 8] <= s_axi_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wstate_q    <= W_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            bid_q       <= '0;
            waddr_q     <= '0;
            wlen_q      <= '0;
            wcnt_q      <= '0;
            wburst_q    <= '0;
            wbad_q      <= 1'b0;
            wlast_err_q <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (s_axi_awvalid && awready_q) begin
                        bid_q       <= s_axi_awid;
                        waddr_q     <= awaddr_al;
                        wlen_q      <= s_axi_awlen;
                        wburst_q    <= s_axi_awburst;
                        wcnt_q      <= '0;
                        wbad_q      <= burst_bad(s_axi_awburst, s_axi_awlen);
                        wlast_err_q <= 1'b0;
                        awready_q   <= 1'b0;
                        wready_q    <= 1'b1;
                        wstate_q    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        waddr_q <= waddr_d;
                        wcnt_q  <= wcnt_q + 8'd1;
                        if (w_last_err) wlast_err_q <= 1'b1;
                        if (w_last_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (wbad_q || wlast_err_q || w_last_err) ? RESP_SLVERR : RESP_OKAY;
                            wstate_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Memory reads use the pre-edge contents, so a same-edge write returns old data
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            rdata_q   <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rburst_q  <= '0;
            rbad_q    <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (s_axi_arvalid && arready_q) begin
                        rid_q     <= s_axi_arid;
                        raddr_q   <= araddr_al;
                        rlen_q    <= s_axi_arlen;
                        rburst_q  <= s_axi_arburst;
                        rcnt_q    <= '0;
                        rbad_q    <= burst_bad(s_axi_arburst, s_axi_arlen);
                        rresp_q   <= burst_bad(s_axi_arburst, s_axi_arlen) ? RESP_SLVERR : RESP_OKAY;
                        rdata_q   <= burst_bad(s_axi_arburst, s_axi_arlen) ? '0 :
                                     mem_q[araddr_al[ADDR_LSB +: MEM_WIDTH_AD]];
                        rlast_q   <= (s_axi_arlen == 8'd0);
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            raddr_q <= raddr_d;
                            rcnt_q  <= rcnt_q + 8'd1;
                            rdata_q <= rbad_q ? '0 : mem_q[raddr_d[ADDR_LSB +: MEM_WIDTH_AD]];
                            rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_spi_axi_mem_slave.sv
// Directed self-checking bench for spi_axi_mem_slave with hand-computed expected values.
module tb_spi_axi_mem_slave;

    logic        aclk, areset;
    logic [3:0]  awid, bid, arid, rid;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wbuf [16];
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    int          rd_n;
    logic [3:0]  r_id_seen;
    logic [1:0]  b_resp_seen;
    logic [3:0]  b_id_seen;

    spi_axi_mem_slave dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // early_last < 0 means wlast is driven correctly on the final beat
    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [3:0] id, input logic [3:0] strb, input int early_last,
                             input int bhold);
        bit ok;
        awaddr = addr; awlen = len; awburst = burst; awid = id; awvalid = 1'b1;
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge aclk);
            if (awready) begin
                ok = 1;
                @(posedge aclk); #1;
            end
        end
        awvalid = 1'b0;
        if (!ok) check("aw_timeout", 0, 1);
        for (int b = 0; b <= int'(len); b++) begin
            wdata  = wbuf[b];
            wstrb  = strb;
            wlast  = (early_last >= 0) ? (b == early_last) : (b == int'(len));
            wvalid = 1'b1;
            ok = 0;
            for (int c = 0; c < 50 && !ok; c++) begin
                @(negedge aclk);
                if (wready) begin
                    ok = 1;
                    @(posedge aclk); #1;
                end
            end
            if (!ok) check("w_timeout", 0, 1);
        end
        wvalid = 1'b0; wlast = 1'b0;
        for (int h = 0; h < bhold; h++) begin
            @(negedge aclk);
            check($sformatf("b_hold[%0d]", h), bvalid, 1);
            check($sformatf("aw_blocked[%0d]", h), awready, 0);
            @(posedge aclk); #1;
        end
        bready = 1'b1;
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge aclk);
            if (bvalid) begin
                ok = 1;
                b_resp_seen = bresp;
                b_id_seen   = bid;
                @(posedge aclk); #1;
            end
        end
        bready = 1'b0;
        if (!ok) check("b_timeout", 0, 1);
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id);
        bit ok;
        araddr = addr; arlen = len; arburst = burst; arid = id; arvalid = 1'b1;
        ok = 0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge aclk);
            if (arready) begin
                ok = 1;
                @(posedge aclk); #1;
            end
        end
        arvalid = 1'b0;
        if (!ok) check("ar_timeout", 0, 1);
    endtask

    // toggle=1 alternates rready 1/0 each cycle and checks rdata/rlast hold during stalls
    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input bit toggle);
        bit done, stalled;
        logic [31:0] sd;
        logic        sl;
        ar_send(addr, len, burst, id);
        rd_n = 0; done = 0; stalled = 0; sd = '0; sl = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            rready = toggle ? (c % 2 == 0) : 1'b1;
            @(negedge aclk);
            if (rvalid) begin
                if (stalled) begin
                    check($sformatf("r_stable_data[%0d]", rd_n), rdata, sd);
                    check($sformatf("r_stable_last[%0d]", rd_n), rlast, sl);
                end
                if (rready) begin
                    if (rd_n == 0) r_id_seen = rid;
                    if (rd_n < 16) begin
                        rd_data[rd_n] = rdata;
                        rd_resp[rd_n] = rresp;
                        rd_last[rd_n] = rlast;
                    end
                    rd_n++;
                    if (rlast) done = 1;
                end
                stalled = !rready;
                sd = rdata; sl = rlast;
            end
            @(posedge aclk); #1;
        end
        rready = 1'b0;
        if (!done) check("r_timeout", 0, 1);
        check("r_beats", rd_n, int'(len) + 1);
    endtask

    initial begin
        areset = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        for (int i = 0; i < 16; i++) wbuf[i] = '0;

        #1 areset = 1'b1;
        #1;
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_wready",  wready,  0);
        check("rst_bvalid",  bvalid,  0);
        check("rst_rvalid",  rvalid,  0);
        check("rst_rdata",   rdata,   0);
        check("rst_bresp",   bresp,   0);
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        @(posedge aclk); #1;
        check("post_rst_awready", awready, 1);
        check("post_rst_arready", arready, 1);

        // INCR write/read of four words
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
        axi_write(32'h10, 8'd3, 2'd1, 4'h5, 4'hF, -1, 0);
        check("incr_bresp", b_resp_seen, 2'd0);
        check("incr_bid",   b_id_seen,   4'h5);
        axi_read(32'h10, 8'd3, 2'd1, 4'h3, 0);
        check("incr_rid", r_id_seen, 4'h3);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("incr_rdata[%0d]", i), rd_data[i], 32'hA0 + i);
            check($sformatf("incr_rlast[%0d]", i), rd_last[i], i == 3);
            check($sformatf("incr_rresp[%0d]", i), rd_resp[i], 2'd0);
        end

        // WRAP read crossing the 16-byte window
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE0030 + 4 * i;
        axi_write(32'h30, 8'd3, 2'd1, 4'h1, 4'hF, -1, 0);
        axi_read(32'h38, 8'd3, 2'd2, 4'h7, 0);
        check("wrap_rdata[0]", rd_data[0], 32'hC0DE0038);
        check("wrap_rdata[1]", rd_data[1], 32'hC0DE003C);
        check("wrap_rdata[2]", rd_data[2], 32'hC0DE0030);
        check("wrap_rdata[3]", rd_data[3], 32'hC0DE0034);
        axi_read(32'h30, 8'd2, 2'd2, 4'h7, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("badwrap_rresp[%0d]", i), rd_resp[i], 2'd2);
            check($sformatf("badwrap_rdata[%0d]", i), rd_data[i], 32'h0);
        end

        // Byte-strobe merge
        wbuf[0] = 32'h11223344;
        axi_write(32'h80, 8'd0, 2'd1, 4'h2, 4'hF, -1, 0);
        wbuf[0] = 32'h0000AA00;
        axi_write(32'h80, 8'd0, 2'd1, 4'h2, 4'h2, -1, 0);
        axi_read(32'h80, 8'd0, 2'd1, 4'h0, 0);
        check("strb_merge", rd_data[0], 32'h1122AA44);
        check("single_rlast", rd_last[0], 1);

        // FIXED write leaves only the last beat, neighbour untouched
        wbuf[0] = 32'h0; wbuf[1] = 32'h55;
        axi_write(32'h90, 8'd1, 2'd1, 4'h0, 4'hF, -1, 0);
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0 + i;
        axi_write(32'h90, 8'd3, 2'd0, 4'h0, 4'hF, -1, 0);
        axi_read(32'h90, 8'd1, 2'd1, 4'h0, 0);
        check("fixed_last_beat", rd_data[0], 32'hC3);
        check("fixed_neighbour", rd_data[1], 32'h55);

        // Backpressure: B held for 5 cycles, rready toggling on an 8-beat read
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h5A000100 + i;
        axi_write(32'h100, 8'd7, 2'd1, 4'h9, 4'hF, -1, 5);
        check("bp_bresp", b_resp_seen, 2'd0);
        check("bp_bid",   b_id_seen,   4'h9);
        axi_read(32'h100, 8'd7, 2'd1, 4'h4, 1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bp_rdata[%0d]", i), rd_data[i], 32'h5A000100 + i);
            check($sformatf("bp_rlast[%0d]", i), rd_last[i], i == 7);
        end

        // Misplaced wlast gives SLVERR
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hE0 + i;
        axi_write(32'h200, 8'd3, 2'd1, 4'h6, 4'hF, 2, 0);
        check("early_wlast_bresp", b_resp_seen, 2'd2);
        check("early_wlast_bid",   b_id_seen,   4'h6);

        // Reserved burst type: SLVERR and data discarded
        wbuf[0] = 32'hDEADBEEF;
        axi_write(32'h10, 8'd0, 2'd3, 4'h3, 4'hF, -1, 0);
        check("bad_burst_bresp", b_resp_seen, 2'd2);
        axi_read(32'h10, 8'd0, 2'd1, 4'h0, 0);
        check("bad_burst_discard", rd_data[0], 32'hA0);

        // Asynchronous reset in the middle of a read burst
        ar_send(32'h100, 8'd7, 2'd1, 4'h2);
        rready = 1'b1;
        @(negedge aclk);
        check("pre_rst_rvalid", rvalid, 1);
        @(posedge aclk); #3;
        areset = 1'b1;
        #1;
        check("mid_rst_rvalid",  rvalid,  0);
        check("mid_rst_rlast",   rlast,   0);
        check("mid_rst_rdata",   rdata,   0);
        check("mid_rst_arready", arready, 0);
        rready = 1'b0;
        @(posedge aclk); #1;
        areset = 1'b0;
        #1;
        check("rel_arready_before_edge", arready, 0);
        @(posedge aclk); #1;
        check("rel_arready_after_edge", arready, 1);
        axi_read(32'h14, 8'd0, 2'd1, 4'h0, 0);
        check("post_rst_read", rd_data[0], 32'hA1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_axi_mem_slave.md
SPI_AXI_MEM_SLAVE -- requirements
Module: spi_axi_mem_slave

Interface
REQ-001 SHALL have parameter AXI_WIDTH_ID, default 4, ID width in bits.
REQ-002 SHALL have parameter AXI_WIDTH_ADDR, default 32, address width.
REQ-003 SHALL have parameter AXI_WIDTH_DATA, default 32, data width (32 or 64); ADDR_LSB = log2(AXI_WIDTH_DATA/8).
REQ-004 SHALL have parameter MEM_WIDTH_AD, default 10, log2 of memory depth in data words.
REQ-005 SHALL have the following ports, one clock, reset asynchronous and active-high:
aclk  in  1  clock, all logic on rising edge
areset  in  1  asynchronous active-high reset
s_axi_awid  in  AXI_WIDTH_ID  write ID
s_axi_awaddr  in  AXI_WIDTH_ADDR  write start byte address
s_axi_awlen  in  8  write beats minus one
s_axi_awburst  in  2  write burst type (0 FIXED, 1 INCR, 2 WRAP)
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  AXI_WIDTH_DATA  write data
s_axi_wstrb  in  AXI_WIDTH_DATA/8  byte enables
s_axi_wlast  in  1  last write beat
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  AXI_WIDTH_ID  response ID
s_axi_bresp  out  2  write response (0 OKAY, 2 SLVERR)
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_arid  in  AXI_WIDTH_ID  read ID
s_axi_araddr  in  AXI_WIDTH_ADDR  read start byte address
s_axi_arlen  in  8  read beats minus one
s_axi_arburst  in  2  read burst type
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  AXI_WIDTH_ID  read ID
s_axi_rdata  out  AXI_WIDTH_DATA  read data
s_axi_rresp  out  2  read response
s_axi_rlast  out  1  last read beat
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Function
REQ-006 SHALL hold 2**MEM_WIDTH_AD words; word index = addr[ADDR_LSB+MEM_WIDTH_AD-1:ADDR_LSB]; higher bits alias; addr[ADDR_LSB-1:0] forced to zero on capture.
REQ-007 SHALL implement transfer size as full width only; lock/cache/prot are not supported.
REQ-008 SHALL run write and read channels independently, one outstanding burst per direction; no cross-channel ordering.
REQ-009 Write FSM SHALL be W_IDLE (awready=1) -> W_DATA on AW handshake (capture id/addr/len/burst, beat count=0) -> W_RESP after beat count==awlen handshake -> W_IDLE on bvalid&&bready; wready=1 only in W_DATA, bvalid=1 only in W_RESP.
REQ-010 Each W handshake SHALL write bytes with wstrb[i]=1 at the current address on that edge, then advance address; bvalid rises the cycle after the last W handshake.
REQ-011 A wlast value disagreeing with (count==awlen) on any beat SHALL set a sticky SLVERR for that burst; the burst still ends at count==awlen.
REQ-012 Read FSM SHALL be R_IDLE (arready=1) -> R_DATA on AR handshake -> R_IDLE on R handshake with rlast=1; rvalid=1 only in R_DATA.
REQ-013 rdata SHALL be registered: loaded from memory on the AR handshake edge and on each non-last R handshake edge (next address); rvalid first asserts the cycle after AR handshake; one beat per cycle while rready=1; rdata/rlast stable while rvalid&&!rready.
REQ-014 Address advance SHALL be: FIXED unchanged; INCR +AXI_WIDTH_DATA/8 (no 4KB check, wraps modulo 2**AXI_WIDTH_ADDR); WRAP with mask=(len+1)*bytes-1: addr=(addr&~mask)|((addr+bytes)&mask).
REQ-015 burst=3, or WRAP with len not in {1,3,7,15}, SHALL give SLVERR: write beats accepted but discarded, read beats return rdata=0, rresp=2 on every beat.
REQ-016 A read load and a write to the same word on the same edge SHALL return the old data.

Reset
REQ-017 areset=1 SHALL force both FSMs to IDLE and awready, arready, wready, bvalid, rvalid, rlast=0, bresp, rresp, bid, rid, rdata=0 immediately; awready/arready rise on the first edge after release; memory is not reset; bursts in flight are abandoned without response.

Verification
REQ-018 INCR awaddr=0x10, awlen=3, data 0xA0..0xA3, wstrb=0xF -> bresp=0, bid=awid; INCR read 0x10 len 3 -> 0xA0..0xA3, rlast on 4th beat only.
REQ-019 WRAP araddr=0x38, arlen=3 (32-bit) -> beat addresses 0x38,0x3C,0x30,0x34; WRAP arlen=2 -> rresp=2 all beats, rdata=0.
REQ-020 Write 0x11223344 then wstrb=0x2 data 0x0000AA00 -> read 0x1122AA44; FIXED write len 3 -> only last beat remains.
REQ-021 rready toggled 1/0 each cycle over 8-beat read, bready held 0 for 5 cycles -> no data loss, bvalid held, awready=0 until B handshake.
REQ-022 wlast=1 on beat 2 of len=3 burst -> bresp=2; areset pulse mid-read -> rvalid=0 at once, arready=1 one edge after release.
